// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel divider, H/V counters and registered sync/visible/frame decodes for VGA timing.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
    $error("vga_sync_gen: totals must fit 10-bit counters and CLK_DIV must be >= 1");
  end
  logic [DW-1:0] div, div_next;
  logic [9:0] h_next, v_next;
  logic h_wrap;
  always_comb begin
    div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
    h_wrap = pixel_tick && (HCount == H_LAST);
    h_next = !pixel_tick ? HCount : h_wrap ? 10'd0 : HCount + 10'd1;
    v_next = !h_wrap ? VCount : (VCount == V_LAST) ? 10'd0 : VCount + 10'd1;
  end
  // decodes use next-state counts so they switch on the same edge as the counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div <= '0;
      HCount <= '0;
      VCount <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      video_on <= 1'b0;
      pixel_tick <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div <= div_next;
      HCount <= h_next;
      VCount <= v_next;
      hsync <= !(h_next >= HS_FIRST && h_next <= HS_LAST);
      vsync <= !(v_next >= VS_FIRST && v_next <= VS_LAST);
      video_on <= (h_next < H_VIS) && (v_next < V_VIS);
      pixel_tick <= (div_next == DIV_LAST);
      frame_start <= h_wrap && (VCount == V_LAST);
    end
  end
endmodule
